hub75_scan_ctrl: RTL and testbench
==================================

Name: hub75_scan_ctrl

Overview:
- Parametrised HUB75 scan controller: drives row addressing, latch and blank for binary-coded-modulation (BCM) refresh.
- Sequences the fetch/shift engine one display slot ahead of the slot currently shown.
- Adds over the previous generation: generic rows/bit depth, shift-register or parallel row addressing, global brightness via blank duty, frame-boundary double-buffer swap, and clean start/stop.

Parameters:
ROWS, 32, scan rows per frame (rows driven simultaneously count once)
ROW_W, 6, row counter/address width; ROW_W >= clog2(ROWS)
BITS, 6, BCM bit planes per row (1..8)
BIT_W, 3, bit counter width; BIT_W >= clog2(BITS)
SHOW_LEN, 32, cycles in the bit-0 display period
DELAY_W, 20, delay counter width; must hold SHOW_LEN<<(BITS-1)
ADDR_MODE, 0, 0 = shift-register row driver (row_clk/row_data); 1 = parallel address on row_addr

Ports:
sys_clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  level; 1 = scan, 0 = finish current slot then park blanked
brightness  in  8  global brightness; on-time scale (brightness+1)/256; sampled at START of each slot
fetchshift_busy  in  1  shift engine busy
swap_req  in  1  level request to flip display buffer at next frame boundary
fetchshift_start  out  1  one-cycle pulse: fetch/shift slot (row_out, bit_out)
bit_out  out  BIT_W  bit plane of slot being fetched; stable from start pulse until busy falls
row_out  out  ROW_W  row of slot being fetched
buf_sel  out  1  buffer the fetch engine reads
swap_ack  out  1  one-cycle pulse when buf_sel toggles
frame_start  out  1  one-cycle pulse when row 0 / bit 0 is latched
lat  out  1  pin: panel latch
blank  out  1  pin: output enable, active-high blank
row_clk  out  1  pin, mode 0 only; held 0 in mode 1
row_data  out  1  pin, mode 0 only; held 0 in mode 1
row_addr  out  ROW_W  pin, mode 1 only; held 0 in mode 0

Behaviour:
- Reset values: blank=1; every other output 0; fetch and display counters (0,0); FSM IDLE. Reset mid-slot takes effect the next cycle with no drain.
- Pins lat/blank/row_clk/row_data/row_addr are registered from state decode, so they lag state by 1 cycle. fetchshift_start, bit_out, row_out, buf_sel, swap_ack and frame_start are not delayed.
- Slot order: bit inner (0..BITS-1), row outer (0..ROWS-1). Slot after (r, BITS-1) is (r+1, 0). Slot after (ROWS-1, BITS-1) is (0, 0). Counters never reach ROWS or BITS.
- States:
  - IDLE: if enable, go to PRELOAD.
  - PRELOAD: start pulse for fetch (0,0).
  - PRELOAD_WAIT: wait for !busy. Display slot := fetch slot; fetch slot advances. Go to BLANK.
  - BLANK: 1 cycle. If display bit==0, go to ROW_DATA (mode 0) or ROW_ADDR (mode 1); else go to LATCH.
  - ROW_DATA (2 cycles): row_data = (display row==0).
  - ROW_CLK (2 cycles): row_clk=1, row_data held.
  - ROW_SETTLE (2 cycles): row_clk=0, row_data=0.
  - ROW_ADDR (3 cycles): row_addr = display row.
  - LATCH (2 cycles): lat=1. frame_start pulses in the first cycle if display slot is (0,0).
  - START: fetchshift_start pulse for the fetch slot; delay counter cleared; brightness captured.
  - SHOW: delay counter increments each cycle. blank=0 while delay_cnt < on_time. Leave when delay_cnt >= period-1 and !busy.
  - NEXT: display slot := fetch slot; fetch slot advances; go to BLANK, or IDLE if !enable.
- Timing arithmetic:
  - period = SHOW_LEN<<bit.
  - on_time = (period*(brightness+1))>>8, full-width product, no truncation before the shift.
  - on_time=0 keeps blank high for the whole SHOW.
  - SHOW length is independent of brightness, so frame rate is constant.
  - If busy outlasts period, blank stays high after on_time and SHOW stretches.
- Buffer swap: evaluated when the fetch slot advances to (0,0), before its start pulse. If swap_req=1, buf_sel toggles and swap_ack pulses in that same cycle. A request held across frames swaps once per frame.
- Simultaneous swap_req and enable fall: swap still occurs if the fetch slot reaches (0,0).

Test Plan:
- ROWS=4, BITS=3, SHOW_LEN=8, brightness=255, busy never asserted -> blank low for 8/16/32 cycles on bits 0/1/2; fetch order (0,1),(0,2),(1,0),...,(0,0) after preload (0,0).
- brightness=127 -> bit-2 on_time 16 cycles, SHOW still 32; brightness=0 on bit 0 -> on_time 0, blank never low.
- ADDR_MODE=0 -> row_data high in the row_clk pulse only for row 0; exactly one 2-cycle row_clk per row, none on bits 1..2. ADDR_MODE=1 -> row_addr steps 0,1,2,3,0 while blank=1, before lat.
- busy held 50 cycles after a bit-0 start -> SHOW lasts 50+ cycles, blank high after cycle 8, no new start until busy falls.
- swap_req raised mid-frame -> single swap_ack and buf_sel toggle at the fetch wrap to (0,0); frame_start pulses at the next latch of (0,0).
- enable dropped mid-SHOW -> slot completes, FSM reaches IDLE with blank=1; rst asserted mid-ROW_CLK -> next cycle state IDLE, row_clk=0 one cycle later.

Source files
------------

// File: rtl/hub75_scan_ctrl.sv
// rtl/hub75_scan_ctrl.sv - HUB75 BCM scan controller: row addressing, latch, blank and fetch sequencing
module hub75_scan_ctrl #(
  parameter int ROWS      = 32,
  parameter int ROW_W     = 6,
  parameter int BITS      = 6,
  parameter int BIT_W     = 3,
  parameter int SHOW_LEN  = 32,
  parameter int DELAY_W   = 20,
  parameter int ADDR_MODE = 0
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               enable,
  input  logic [7:0]         brightness,
  input  logic               fetchshift_busy,
  input  logic               swap_req,
  output logic               fetchshift_start,
  output logic [BIT_W-1:0]   bit_out,
  output logic [ROW_W-1:0]   row_out,
  output logic               buf_sel,
  output logic               swap_ack,
  output logic               frame_start,
  output logic               lat,
  output logic               blank,
  output logic               row_clk,
  output logic               row_data,
  output logic [ROW_W-1:0]   row_addr
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_PRELOAD,
    S_PRELOAD_WAIT,
    S_BLANK,
    S_ROW_DATA,
    S_ROW_CLK,
    S_ROW_SETTLE,
    S_ROW_ADDR,
    S_LATCH,
    S_START,
    S_SHOW,
    S_NEXT
  } state_t;

  localparam int                 PROD_W    = DELAY_W + 9;
  localparam logic [ROW_W-1:0]   ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(BITS - 1);
  localparam logic [DELAY_W-1:0] SHOW_BASE = DELAY_W'(SHOW_LEN);
  localparam logic [DELAY_W-1:0] DELAY_MAX = '1;

  state_t             state;
  state_t             state_nxt;
  logic [1:0]         step_cnt;
  logic [ROW_W-1:0]   fetch_row;
  logic [ROW_W-1:0]   fetch_row_nxt;
  logic [ROW_W-1:0]   disp_row;
  logic [BIT_W-1:0]   fetch_bit;
  logic [BIT_W-1:0]   fetch_bit_nxt;
  logic [BIT_W-1:0]   disp_bit;
  logic [DELAY_W-1:0] delay_cnt;
  logic [DELAY_W-1:0] on_time;
  logic [DELAY_W-1:0] period;
  logic [PROD_W-1:0]  on_prod;
  logic               advance;
  logic               fetch_wrap;
  logic               show_on;

  assign row_out = fetch_row;
  assign bit_out = fetch_bit;

  // Full-width product so low brightness on short bit planes rounds down to zero cleanly
  assign period  = SHOW_BASE << disp_bit;
  assign on_prod = PROD_W'(period) * (PROD_W'(brightness) + PROD_W'(1));
  assign show_on = (state == S_SHOW) && (delay_cnt < on_time);

  always_comb begin
    fetch_bit_nxt = fetch_bit;
    fetch_row_nxt = fetch_row;
    if (fetch_bit == BIT_LAST) begin
      fetch_bit_nxt = '0;
      fetch_row_nxt = (fetch_row == ROW_LAST) ? '0 : fetch_row + ROW_W'(1);
    end else begin
      fetch_bit_nxt = fetch_bit + BIT_W'(1);
    end
    fetch_wrap = (fetch_bit_nxt == '0) && (fetch_row_nxt == '0);
  end

  always_comb begin
    state_nxt        = state;
    fetchshift_start = 1'b0;
    frame_start      = 1'b0;
    advance          = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_PRELOAD;
      end
      S_PRELOAD: begin
        fetchshift_start = 1'b1;
        state_nxt        = S_PRELOAD_WAIT;
      end
      S_PRELOAD_WAIT: begin
        if (!fetchshift_busy) begin
          advance   = 1'b1;
          state_nxt = S_BLANK;
        end
      end
      S_BLANK: begin
        if (disp_bit == '0) state_nxt = (ADDR_MODE == 0) ? S_ROW_DATA : S_ROW_ADDR;
        else                state_nxt = S_LATCH;
      end
      S_ROW_DATA: begin
        if (step_cnt == 2'd1) state_nxt = S_ROW_CLK;
      end
      S_ROW_CLK: begin
        if (step_cnt == 2'd1) state_nxt = S_ROW_SETTLE;
      end
      S_ROW_SETTLE: begin
        if (step_cnt == 2'd1) state_nxt = S_LATCH;
      end
      S_ROW_ADDR: begin
        if (step_cnt == 2'd2) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        frame_start = (step_cnt == 2'd0) && (disp_row == '0) && (disp_bit == '0);
        if (step_cnt == 2'd1) state_nxt = S_START;
      end
      S_START: begin
        fetchshift_start = 1'b1;
        state_nxt        = S_SHOW;
      end
      S_SHOW: begin
        // A slow shift engine stretches the slot rather than cutting it short
        if ((delay_cnt >= period - DELAY_W'(1)) && !fetchshift_busy) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        advance   = 1'b1;
        state_nxt = enable ? S_BLANK : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      step_cnt  <= 2'd0;
      fetch_row <= '0;
      fetch_bit <= '0;
      disp_row  <= '0;
      disp_bit  <= '0;
      delay_cnt <= '0;
      on_time   <= '0;
      buf_sel   <= 1'b0;
      swap_ack  <= 1'b0;
      lat       <= 1'b0;
      blank     <= 1'b1;
      row_clk   <= 1'b0;
      row_data  <= 1'b0;
      row_addr  <= '0;
    end else begin
      state    <= state_nxt;
      step_cnt <= (state_nxt != state) ? 2'd0 : step_cnt + 2'd1;
      swap_ack <= 1'b0;

      if (state == S_IDLE && enable) begin
        fetch_row <= '0;
        fetch_bit <= '0;
      end

      // Display takes over the slot just fetched; buffer flips only at the frame wrap
      if (advance) begin
        disp_row  <= fetch_row;
        disp_bit  <= fetch_bit;
        fetch_row <= fetch_row_nxt;
        fetch_bit <= fetch_bit_nxt;
        if (fetch_wrap && swap_req) begin
          buf_sel  <= ~buf_sel;
          swap_ack <= 1'b1;
        end
      end

      if (state == S_START) begin
        delay_cnt <= '0;
        on_time   <= DELAY_W'(on_prod >> 8);
      end else if (state == S_SHOW && delay_cnt != DELAY_MAX) begin
        delay_cnt <= delay_cnt + DELAY_W'(1);
      end

      lat      <= (state == S_LATCH);
      blank    <= !show_on;
      row_clk  <= (ADDR_MODE == 0) && (state == S_ROW_CLK);
      row_data <= (ADDR_MODE == 0) && (state == S_ROW_DATA || state == S_ROW_CLK) && (disp_row == '0);
      row_addr <= (ADDR_MODE == 1 && state == S_ROW_ADDR) ? disp_row : '0;
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// tb/tb_hub75_scan_ctrl.sv - directed scoreboard bench for hub75_scan_ctrl in both addressing modes
module tb_hub75_scan_ctrl;

  localparam int ROWS = 4, ROW_W = 2, BITS = 3, BIT_W = 2, SHOW_LEN = 8, DELAY_W = 8;

  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  logic en0 = 1'b0;
  logic en1 = 1'b0;
  logic busy = 1'b0;
  logic swap_req = 1'b0;
  logic [7:0] brightness = 8'd255;

  logic fs0, bs0, sa0, fr0, lat0, blank0, rclk0, rdat0;
  logic fs1, bs1, sa1, fr1, lat1, blank1, rclk1, rdat1;
  logic [BIT_W-1:0] bit0, bit1;
  logic [ROW_W-1:0] row0, row1, raddr0, raddr1;

  always #5 sys_clk = ~sys_clk;

  hub75_scan_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .BITS(BITS), .BIT_W(BIT_W),
                    .SHOW_LEN(SHOW_LEN), .DELAY_W(DELAY_W), .ADDR_MODE(0)) u0 (
    .sys_clk(sys_clk), .rst(rst), .enable(en0), .brightness(brightness),
    .fetchshift_busy(busy), .swap_req(swap_req), .fetchshift_start(fs0),
    .bit_out(bit0), .row_out(row0), .buf_sel(bs0), .swap_ack(sa0),
    .frame_start(fr0), .lat(lat0), .blank(blank0), .row_clk(rclk0),
    .row_data(rdat0), .row_addr(raddr0)
  );

  hub75_scan_ctrl #(.ROWS(ROWS), .ROW_W(ROW_W), .BITS(BITS), .BIT_W(BIT_W),
                    .SHOW_LEN(SHOW_LEN), .DELAY_W(DELAY_W), .ADDR_MODE(1)) u1 (
    .sys_clk(sys_clk), .rst(rst), .enable(en1), .brightness(brightness),
    .fetchshift_busy(busy), .swap_req(swap_req), .fetchshift_start(fs1),
    .bit_out(bit1), .row_out(row1), .buf_sel(bs1), .swap_ack(sa1),
    .frame_start(fr1), .lat(lat1), .blank(blank1), .row_clk(rclk1),
    .row_data(rdat1), .row_addr(raddr1)
  );

  int total = 0, bad = 0;
  int cyc_num = 0, start_num = 0, last_start_cyc = 0, start_gap = 0, last_slot = 0;
  int low_run = 0, low_total = 0;
  int rclk_cyc = 0, rclk_rise = 0, rclk_data_cyc = 0, rdata_cyc = 0;
  int frame_cnt = 0, swap_cnt = 0;
  int raddr_nz = 0, raddr_unblanked = 0, u1_rowpin = 0, u0_addrpin = 0;
  logic rclk0_prev = 1'b0;
  logic lat1_prev = 1'b0;
  logic [ROW_W-1:0] raddr1_prev = '0;
  int exp_fetch[$];
  int exp_low[$];
  int exp_addr[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock step; outputs are sampled 1 time unit after the edge and scoreboards popped
  task automatic cyc();
    @(posedge sys_clk);
    #1;
    cyc_num++;
    if (fs0) begin
      start_num++;
      start_gap      = cyc_num - last_start_cyc;
      last_start_cyc = cyc_num;
      last_slot      = int'({row0, bit0});
      if (exp_fetch.size() > 0) check("fetch_slot", last_slot, exp_fetch.pop_front());
    end
    if (!blank0) begin
      low_run++;
      low_total++;
    end else if (low_run > 0) begin
      if (exp_low.size() > 0) check("blank_low_len", low_run, exp_low.pop_front());
      low_run = 0;
    end
    if (rclk0) begin
      rclk_cyc++;
      if (rdat0) rclk_data_cyc++;
    end
    if (rclk0 && !rclk0_prev) rclk_rise++;
    if (rdat0) rdata_cyc++;
    rclk0_prev = rclk0;
    if (fr0) frame_cnt++;
    if (sa0) swap_cnt++;
    if (raddr0 != '0) u0_addrpin++;
    if (rclk1 || rdat1) u1_rowpin++;
    if (raddr1 != '0) begin
      raddr_nz++;
      if (!blank1) raddr_unblanked++;
    end
    if (lat1 && !lat1_prev && exp_addr.size() > 0)
      check("row_addr_before_lat", raddr1_prev, exp_addr.pop_front());
    lat1_prev   = lat1;
    raddr1_prev = raddr1;
  endtask

  task automatic wait_start(input int n, input string tag);
    int guard = 0;
    while (start_num < n && guard < 2000) begin
      cyc();
      guard++;
    end
    check(tag, start_num >= n, 1);
  endtask

  initial begin
    int guard;
    int snap;

    rst = 1'b1;
    cyc();
    cyc();
    check("rst_blank", blank0, 1);
    check("rst_lat", lat0, 0);
    check("rst_start", fs0, 0);
    check("rst_row_out", row0, 0);
    check("rst_bit_out", bit0, 0);
    check("rst_buf_sel", bs0, 0);
    check("rst_swap_ack", sa0, 0);
    check("rst_frame_start", fr0, 0);
    check("rst_row_pins", {rclk0, rdat0, raddr0}, 0);
    check("rst_m1_outs", {fs1, bs1, sa1, fr1, lat1, row1, bit1}, 0);
    check("rst_m1_blank", blank1, 1);
    rst = 1'b0;

    // Full frame at brightness 255: fetch order, BCM on-times, row driver pulses
    exp_fetch.push_back(0);
    for (int i = 1; i <= 13; i++) begin
      int s;
      s = i % 12;
      exp_fetch.push_back((s / 3) * 4 + (s % 3));
    end
    for (int i = 0; i < 12; i++) exp_low.push_back(SHOW_LEN << (i % 3));
    en0 = 1'b1;
    wait_start(14, "frame1_starts");
    check("fetch_queue_drained", exp_fetch.size(), 0);
    check("low_queue_drained", exp_low.size(), 0);
    check("row_clk_cycles", rclk_cyc, 10);
    check("row_clk_pulses", rclk_rise, 5);
    check("row_data_in_clk", rclk_data_cyc, 4);
    check("row_data_cycles", rdata_cyc, 8);
    check("frame_start_count", frame_cnt, 2);
    check("no_swap_yet", swap_cnt, 0);

    // Brightness 127 then 0; slot length must not change
    exp_low.push_back(8);
    exp_low.push_back(8);
    exp_low.push_back(16);
    cyc();
    brightness = 8'd127;
    wait_start(16, "start16");
    cyc();
    brightness = 8'd0;
    wait_start(17, "start17");
    check("bit2_gap_const", start_gap, 43);
    check("half_bright_drained", exp_low.size(), 0);
    snap = low_total;
    cyc();
    brightness = 8'd255;
    wait_start(18, "start18");
    check("zero_on_time_no_unblank", low_total, snap);

    // Busy held 50 cycles over a bit-0 slot
    wait_start(20, "start20");
    exp_low.push_back(8);
    busy = 1'b1;
    repeat (50) cyc();
    check("no_start_while_busy", start_num, 20);
    busy = 1'b0;
    wait_start(21, "start21");
    check("busy_stretch_gap", start_gap, 55);
    check("busy_low_drained", exp_low.size(), 0);

    // Buffer swap at the fetch wrap, then frame_start at the latch of (0,0)
    swap_req = 1'b1;
    guard = 0;
    while (!sa0 && guard < 600) begin
      cyc();
      guard++;
    end
    check("swap_ack_seen", sa0, 1);
    check("swap_fetch_row", row0, 0);
    check("swap_fetch_bit", bit0, 0);
    check("swap_buf_sel", bs0, 1);
    snap = start_num;
    swap_req = 1'b0;
    guard = 0;
    while (!fr0 && guard < 400) begin
      cyc();
      guard++;
    end
    check("frame_start_seen", fr0, 1);
    check("frame_start_last_fetch", last_slot, 0);
    check("starts_swap_to_frame", start_num - snap, 1);
    check("single_swap", swap_cnt, 1);

    // Enable dropped mid-SHOW: slot completes, then parks blanked
    wait_start(start_num + 1, "stop_slot_start");
    exp_low.push_back(8);
    repeat (3) cyc();
    en0 = 1'b0;
    snap = start_num;
    repeat (100) cyc();
    check("parked_no_start", start_num, snap);
    check("parked_blank", blank0, 1);
    check("parked_lat", lat0, 0);
    check("stop_slot_completed", exp_low.size(), 0);
    exp_fetch.push_back(0);
    en0 = 1'b1;
    wait_start(snap + 1, "restart_preload");
    check("restart_fetch_drained", exp_fetch.size(), 0);

    // Reset in the middle of ROW_CLK
    guard = 0;
    while (!rclk0 && guard < 100) begin
      cyc();
      guard++;
    end
    check("reached_row_clk", rclk0, 1);
    rst = 1'b1;
    cyc();
    check("rst_mid_row_clk", rclk0, 0);
    check("rst_mid_row_data", rdat0, 0);
    check("rst_mid_blank", blank0, 1);
    check("rst_mid_start", fs0, 0);
    check("rst_mid_slot", {row0, bit0}, 0);
    check("rst_mid_buf_sel", bs0, 0);
    en0 = 1'b0;
    rst = 1'b0;
    cyc();
    check("post_rst_row_clk", rclk0, 0);
    check("post_rst_idle", fs0, 0);

    // Parallel addressing: row_addr per bit-0 latch, only while blanked
    for (int i = 0; i < 13; i++) exp_addr.push_back((i % 3 == 0) ? ((i / 3) % 4) : 0);
    en1 = 1'b1;
    guard = 0;
    while (exp_addr.size() > 0 && guard < 1500) begin
      cyc();
      guard++;
    end
    check("addr_queue_drained", exp_addr.size(), 0);
    check("row_addr_cycles", raddr_nz, 9);
    check("row_addr_unblanked", raddr_unblanked, 0);
    check("mode1_row_pins_low", u1_rowpin, 0);
    check("mode0_row_addr_low", u0_addrpin, 0);
    en1 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
